// File: rtl/conv_pkg.sv
// Shared constants for the conv/pool engine: kernels, biases,
// result-RAM select codes, FSM states and 3x3 tap offsets.
package conv_pkg;

  localparam int KW_W = 20;

  typedef logic signed [KW_W-1:0] coef_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TAP  = 3'd1;
  localparam logic [2:0] ST_CWR  = 3'd2;
  localparam logic [2:0] ST_PRD  = 3'd3;
  localparam logic [2:0] ST_PWR  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [2:0] CSEL_IDLE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  localparam coef_t KW [2][9] = '{
    '{20'h0A89E, 20'h092D5, 20'h06D43,
      20'h01004, 20'hF8F71, 20'hF6E54,
      20'hFA6D7, 20'hFC834, 20'hFAC19},
    '{20'hFDB55, 20'h02992, 20'hFC994,
      20'h050FD, 20'h02F20, 20'h0202D,
      20'h03BD7, 20'hFD369, 20'h05E68}
  };

  localparam coef_t KB [2] = '{20'h01310, 20'hF7295};

  // two's complement offsets: 2'b11 = -1
  localparam logic [1:0] TAP_DR [9] = '{
    2'b11, 2'b11, 2'b11,
    2'b00, 2'b00, 2'b00,
    2'b01, 2'b01, 2'b01};

  localparam logic [1:0] TAP_DC [9] = '{
    2'b11, 2'b00, 2'b01,
    2'b11, 2'b00, 2'b01,
    2'b11, 2'b00, 2'b01};

endpackage

// File: rtl/conv_mac.sv
// 3x3 multiply-accumulate with bias preload,
// round-half-up, signed saturation and optional ReLU.
module conv_mac #(
  parameter int DATA_W  = 20,
  parameter int FRAC    = 16,
  parameter int RELU_EN = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] idata,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [DATA_W-1:0] bias,
  output logic        [DATA_W-1:0] result
);

  localparam int ACC_W = 2*DATA_W + 4;

  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    bias_sh;
  logic signed [ACC_W-1:0]    shr;
  logic signed [ACC_W-1:0]    rnd;
  logic        [DATA_W-1:0]   res;

  assign prod    = idata * weight;
  assign bias_sh = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC;

  // tap 0 reloads with the shifted bias instead of zero
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clear ? bias_sh : acc)
           + {{4{prod[2*DATA_W-1]}}, prod};
    end
  end

  assign shr = acc >>> FRAC;
  assign rnd = shr + ACC_W'(acc[FRAC-1]);

  always_comb begin
    res = rnd[DATA_W-1:0];
    if (rnd > SMAX) begin
      res = SMAX[DATA_W-1:0];
    end else if (rnd < SMIN) begin
      res = SMIN[DATA_W-1:0];
    end
    if (RELU_EN != 0 && res[DATA_W-1]) begin
      res = '0;
    end
  end

  assign result = res;

endmodule

// File: rtl/conv_pool_engine.sv
// Padded 3x3 conv + bias (+ReLU) to layer 0, then optional
// 2x2/stride-2 max-pool to layer 1, for each kernel in turn.
module conv_pool_engine
  import conv_pkg::*;
#(
  parameter int IMG_W   = 64,
  parameter int DATA_W  = 20,
  parameter int FRAC    = 16,
  parameter int NUM_K   = 1,
  parameter int RELU_EN = 1,
  parameter int POOL_EN = 1,
  localparam int AW     = 2*$clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [AW-1:0]     iaddr,
  input  logic [DATA_W-1:0] idata,
  output logic              crd,
  output logic [AW-1:0]     caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [AW-1:0]     caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel
);

  localparam int LW = AW / 2;

  logic [2:0]              state;
  logic [LW-1:0]           row, col;
  logic [LW-2:0]           pr, pc;
  logic [3:0]              tap;
  logic [1:0]              pq;
  logic                    kern;
  logic signed [DATA_W-1:0] pmax;
  logic [AW-1:0]           iaddr_q;

  logic [1:0]       dr, dc;
  logic [LW:0]      trow, tcol;
  logic             pad;
  logic [AW-1:0]    tap_addr;
  logic             k_last;
  logic [2:0]       csel_l0, csel_l1;
  logic [DATA_W-1:0] mac_res;
  logic [DATA_W-1:0] mac_x;

  assign dr   = TAP_DR[tap];
  assign dc   = TAP_DC[tap];
  assign trow = {1'b0, row} + {{(LW-1){dr[1]}}, dr};
  assign tcol = {1'b0, col} + {{(LW-1){dc[1]}}, dc};
  // under/overflow past either edge sets the extra MSB
  assign pad      = trow[LW] | tcol[LW];
  assign tap_addr = {trow[LW-1:0], tcol[LW-1:0]};

  assign k_last  = (kern == 1'(NUM_K-1));
  assign csel_l0 = CSEL_L0 + {2'b00, kern};
  assign csel_l1 = CSEL_L1 + {2'b00, kern};
  assign mac_x   = pad ? '0 : idata;

  conv_mac #(
    .DATA_W  (DATA_W),
    .FRAC    (FRAC),
    .RELU_EN (RELU_EN)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (tap == 4'd0),
    .en     (state == ST_TAP),
    .idata  (mac_x),
    .weight (DATA_W'(KW[kern][tap])),
    .bias   (DATA_W'(KB[kern])),
    .result (mac_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      row     <= '0;
      col     <= '0;
      pr      <= '0;
      pc      <= '0;
      tap     <= '0;
      pq      <= '0;
      kern    <= 1'b0;
      pmax    <= '0;
      iaddr_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ready) begin
            state <= ST_TAP;
            kern  <= 1'b0;
            row   <= '0;
            col   <= '0;
            pr    <= '0;
            pc    <= '0;
            tap   <= '0;
            pq    <= '0;
          end
        end
        ST_TAP: begin
          if (!pad) iaddr_q <= tap_addr;
          if (tap == 4'd8) begin
            tap   <= '0;
            state <= ST_CWR;
          end else begin
            tap <= tap + 4'd1;
          end
        end
        ST_CWR: begin
          state <= ST_TAP;
          col   <= col + 1'b1;
          if (&col) begin
            row <= row + 1'b1;
            if (&row) begin
              if (POOL_EN != 0) begin
                state <= ST_PRD;
              end else if (k_last) begin
                state <= ST_DONE;
              end else begin
                kern <= 1'b1;
              end
            end
          end
        end
        ST_PRD: begin
          pq <= pq + 2'd1;
          if (pq == 2'd0 || $signed(cdata_rd) > pmax) begin
            pmax <= cdata_rd;
          end
          if (pq == 2'd3) state <= ST_PWR;
        end
        ST_PWR: begin
          state <= ST_PRD;
          pc    <= pc + 1'b1;
          if (&pc) begin
            pr <= pr + 1'b1;
            if (&pr) begin
              if (k_last) begin
                state <= ST_DONE;
              end else begin
                kern  <= 1'b1;
                state <= ST_TAP;
              end
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    iaddr    = '0;
    crd      = 1'b0;
    caddr_rd = '0;
    cwr      = 1'b0;
    caddr_wr = '0;
    cdata_wr = '0;
    csel     = CSEL_IDLE;
    unique case (1'b1)
      (state == ST_TAP): begin
        iaddr = pad ? iaddr_q : tap_addr;
        csel  = csel_l0;
      end
      (state == ST_CWR): begin
        cwr      = 1'b1;
        caddr_wr = {row, col};
        cdata_wr = mac_res;
        csel     = csel_l0;
      end
      (state == ST_PRD): begin
        crd      = 1'b1;
        caddr_rd = {pr, pq[1], pc, pq[0]};
        csel     = csel_l0;
      end
      (state == ST_PWR): begin
        cwr      = 1'b1;
        caddr_wr = {2'b00, pr, pc};
        cdata_wr = pmax;
        csel     = csel_l1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Bench for conv_pool_engine: image ROM and result RAM models,
// arithmetic reference for every write, plus literal pins.
module tb_conv_pool_engine;
  import conv_pkg::*;

  localparam int N     = 16;
  localparam int DW    = 20;
  localparam int NK    = 2;
  localparam int RELU  = 0;
  localparam int POOL  = 1;
  localparam int AW    = 8;
  localparam int NPIX  = N*N;
  localparam int NPOOL = NPIX/4;
  localparam int BUSY_LEN = NK*(10*NPIX + POOL*5*NPOOL) + 1;
  localparam int LIMIT = BUSY_LEN + 200;

  typedef struct {
    logic [2:0]    sel;
    int            addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ready = 1'b0;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  logic signed [DW-1:0] img [NPIX];
  logic [DW-1:0] ram [8][NPIX];
  wr_t exp_q [$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  conv_pool_engine #(
    .IMG_W(N), .DATA_W(DW), .FRAC(16),
    .NUM_K(NK), .RELU_EN(RELU), .POOL_EN(POOL)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .csel(csel)
  );

  assign idata    = img[iaddr];
  assign cdata_rd = ram[csel][caddr_rd];

  always @(posedge clk) begin
    if (cwr) ram[csel][caddr_wr] <= cdata_wr;
  end

  function automatic int conv_ref(int k, int r, int c);
    longint acc, q;
    int rr, cc;
    acc = longint'(KB[k]) * 65536;
    for (int t = 0; t < 9; t++) begin
      rr = r + t/3 - 1;
      cc = c + t%3 - 1;
      if (rr >= 0 && rr < N && cc >= 0 && cc < N)
        acc += longint'(img[rr*N+cc]) * longint'(KW[k][t]);
    end
    q = (acc + 32768) >>> 16;
    if (q > 524287) q = 524287;
    if (q < -524288) q = -524288;
    if (RELU != 0 && q < 0) q = 0;
    return int'(q);
  endfunction

  function automatic void build_expect();
    int l0 [NPIX];
    int m, b;
    for (int k = 0; k < NK; k++) begin
      for (int p = 0; p < NPIX; p++) begin
        l0[p] = conv_ref(k, p/N, p%N);
        exp_q.push_back('{3'(1+k), p, DW'(l0[p])});
      end
      if (POOL != 0) begin
        for (int r = 0; r < N/2; r++) begin
          for (int c = 0; c < N/2; c++) begin
            b = 2*r*N + 2*c;
            m = l0[b];
            if (l0[b+1] > m) m = l0[b+1];
            if (l0[b+N] > m) m = l0[b+N];
            if (l0[b+N+1] > m) m = l0[b+N+1];
            exp_q.push_back('{3'(3+k), r*(N/2)+c, DW'(m)});
          end
        end
      end
    end
  endfunction

  // per-cycle compare of every result-RAM write
  always @(negedge clk) begin : cmp
    wr_t e;
    if (busy === 1'b1) begin
      total++;
      if (crd && cwr) begin
        bad++;
        $display("FAIL rd_wr_overlap crd=%b cwr=%b want not both", crd, cwr);
      end
    end
    if (cwr === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_write sel=%0d addr=%0d data=%h want none",
                 csel, caddr_wr, cdata_wr);
      end else begin
        e = exp_q.pop_front();
        if (csel !== e.sel || caddr_wr !== AW'(e.addr)
            || cdata_wr !== e.data) begin
          bad++;
          $display("FAIL write got sel=%0d addr=%0d data=%h want sel=%0d addr=%0d data=%h",
                   csel, caddr_wr, cdata_wr, e.sel, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic chk_int(string nm, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_full(string nm);
    int n;
    build_expect();
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
    wait_idle(n);
    chk_int({nm, "_busy_len"}, n, BUSY_LEN);
    chk_int({nm, "_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic fill_rand(int full);
    for (int i = 0; i < NPIX; i++) begin
      if (full != 0) img[i] = DW'($urandom);
      else img[i] = DW'(int'($urandom_range(131072)) - 65536);
    end
  endtask

  initial begin
    int n, cnt;
    for (int i = 0; i < NPIX; i++) img[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_cwr", DW'(cwr), '0);
    chk("rst_crd", DW'(crd), '0);
    chk("rst_csel", DW'(csel), '0);
    chk("rst_iaddr", DW'(iaddr), '0);
    chk("rst_cdata_wr", cdata_wr, '0);
    reset = 1'b0;
    @(negedge clk);

    run_full("zero");
    chk("zero_l0k0", ram[1][0], 20'h01310);
    chk("zero_l0k1", ram[2][5], 20'hF7295);
    chk("zero_l1k0", ram[3][0], 20'h01310);
    chk("zero_l1k1", ram[4][NPOOL-1], 20'hF7295);

    img[8*N+8] = 20'h10000;
    run_full("center");
    chk("center_tap4", ram[1][8*N+8], 20'hFA281);
    chk("center_tap8", ram[1][7*N+7], 20'hFBF29);
    chk("center_pool", ram[3][4*(N/2)+4], 20'h0BBAE);
    chk("center_pool_bias", ram[3][3*(N/2)+3], 20'h01310);
    img[8*N+8] = '0;

    img[0] = 20'h10000;
    run_full("corner");
    cnt = 0;
    for (int p = 0; p < NPIX; p++)
      if (ram[1][p] !== 20'h01310) cnt++;
    chk_int("corner_diff_count", cnt, 4);
    chk("corner_tap0", ram[1][N+1], 20'h0BBAE);

    fill_rand(0);
    run_full("rand_small");
    fill_rand(1);
    run_full("rand_full");

    fill_rand(1);
    build_expect();
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
    repeat (999) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", DW'(busy), '0);
    chk("abort_cwr", DW'(cwr), '0);
    chk("abort_crd", DW'(crd), '0);
    chk("abort_csel", DW'(csel), '0);
    exp_q.delete();
    fill_rand(0);
    run_full("restart");

    fill_rand(1);
    build_expect();
    build_expect();
    @(negedge clk) ready = 1'b1;
    @(negedge clk);
    wait_idle(n);
    chk_int("hold_first_len", n, BUSY_LEN);
    chk("hold_gap_busy", DW'(busy), '0);
    @(negedge clk);
    chk("hold_restart_busy", DW'(busy), 20'h1);
    ready = 1'b0;
    wait_idle(n);
    chk_int("hold_second_len", n, BUSY_LEN);
    chk_int("hold_writes_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
